// File: rtl/param_instr_cache.sv
// N-way set-associative instruction cache: blocking miss handling, burst line refill,
// round-robin replacement, flush and saturating hit/miss counters.
module param_instr_cache #(
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              resp_valid_o,
    output logic [31:0]       instr_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TW = ADDR_W - IB - OB - 2;
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REQ, S_BURST, S_RESP} state_e;

    state_e                    state_q;
    logic [ADDR_W-3:0]         waddr_q;
    logic [WAYS-1:0][SETS-1:0] valid_q;
    logic [TW-1:0]             tag_mem_q [WAYS][SETS];
    logic [WW-1:0]             rr_q [SETS];
    logic [WW-1:0]             victim_q;
    logic [OB-1:0]             beat_q;
    logic                      flush_pend_q;
    logic                      resp_valid_q;
    logic [31:0]               instr_q;
    logic                      mem_req_q;
    logic [ADDR_W-1:0]         mem_addr_q;
    logic [31:0]               hit_cnt_q;
    logic [31:0]               miss_cnt_q;
    logic [31:0]               refill_word_q;

    logic [OB-1:0]             req_off;
    logic [IB-1:0]             req_idx;
    logic [TW-1:0]             req_tag;
    logic [IB+OB-1:0]          rd_addr;
    logic [WAYS-1:0]           hit_vec;
    logic [WW-1:0]             hit_way;
    logic [31:0]               rd_data [WAYS];
    logic                      last_beat;
    logic                      unused_addr_bits;

    assign req_off          = waddr_q[OB-1:0];
    assign req_idx          = waddr_q[IB+OB-1:OB];
    assign req_tag          = waddr_q[ADDR_W-3:IB+OB];
    assign rd_addr          = addr_i[IB+OB+1:2];
    assign last_beat        = mem_rvalid_i && (beat_q == OB'(LINE_WORDS - 1));
    assign unused_addr_bits = &{1'b0, addr_i[1:0]};

    assign req_ready_o  = (state_q == S_IDLE) && !flush_i && !flush_pend_q;
    assign resp_valid_o = resp_valid_q;
    assign instr_o      = instr_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

    // Each way's data RAM is read with the incoming address so the word is ready in LOOKUP.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [31:0] data_mem [SETS*LINE_WORDS];
        logic [31:0] rd_q;
        always_ff @(posedge clk) begin
            if (state_q == S_BURST && mem_rvalid_i && victim_q == WW'(gi))
                data_mem[{req_idx, beat_q}] <= mem_rdata_i;
            rd_q <= data_mem[rd_addr];
        end
        assign rd_data[gi] = rd_q;
        assign hit_vec[gi] = valid_q[gi][req_idx] && (tag_mem_q[gi][req_idx] == req_tag);
    end

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (hit_vec[w]) hit_way = WW'(w);
    end

    always_ff @(posedge clk) begin
        if (state_q == S_BURST && last_beat)
            tag_mem_q[victim_q][req_idx] <= req_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            waddr_q       <= '0;
            valid_q       <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
            victim_q      <= '0;
            beat_q        <= '0;
            flush_pend_q  <= 1'b0;
            resp_valid_q  <= 1'b0;
            instr_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            refill_word_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (flush_i && state_q != S_IDLE) flush_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (flush_i || flush_pend_q) begin
                        valid_q      <= '0;
                        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (req_valid_i) begin
                        waddr_q <= addr_i[ADDR_W-1:2];
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (|hit_vec) begin
                        resp_valid_q <= 1'b1;
                        instr_q      <= rd_data[hit_way];
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
                        state_q      <= S_IDLE;
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
                        victim_q   <= rr_q[req_idx];
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {waddr_q[ADDR_W-3:OB], {(OB+2){1'b0}}};
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (mem_rvalid_i) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == req_off) refill_word_q <= mem_rdata_i;
                        if (last_beat) begin
                            valid_q[victim_q][req_idx] <= 1'b1;
                            rr_q[req_idx] <= (rr_q[req_idx] == WW'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
                            resp_valid_q  <= 1'b1;
                            instr_q       <= (beat_q == req_off) ? mem_rdata_i : refill_word_q;
                            state_q       <= S_RESP;
                        end
                    end
                end
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_instr_cache.sv
// Directed bench for param_instr_cache: a behavioural refill memory answers bursts with
// data {tag, 8'h00, byte address[15:0]} so every expected instruction is known up front.
module tb_param_instr_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] addr_i = '0;
    logic        resp_valid_o;
    logic [31:0] instr_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_mem_req = 0;
    int          gnt_delay = 0;
    int          beat_gap = 0;
    bit          flush_in_burst = 1'b0;
    logic [7:0]  data_tag = 8'hA0;
    logic [31:0] last_line = '0;

    param_instr_cache dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .addr_i(addr_i),
        .resp_valid_o(resp_valid_o), .instr_o(instr_o), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Refill memory: grant after gnt_delay cycles, then four beats separated by beat_gap idle cycles.
    initial begin
        logic [31:0] line;
        logic [7:0]  cap_tag;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                line = mem_addr_o;
                cap_tag = data_tag;
                last_line = line;
                n_mem_req++;
                repeat (gnt_delay) @(negedge clk);
                mem_gnt_i = 1'b1;
                @(negedge clk);
                mem_gnt_i = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    repeat (beat_gap) @(negedge clk);
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = {cap_tag, 8'h00, line[15:0] + 16'(4 * k)};
                    flush_i = flush_in_burst && (k == 1);
                    @(negedge clk);
                    mem_rvalid_i = 1'b0;
                    flush_i = 1'b0;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output logic [31:0] instr, output int lat,
                         output bit ready_bad);
        int w;
        ready_bad = 1'b0;
        lat = 0;
        w = 0;
        @(negedge clk);
        while (!req_ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        req_valid_i = 1'b1;
        addr_i = a;
        @(negedge clk);
        req_valid_i = 1'b0;
        lat = 1;
        while (!resp_valid_o && lat < 400) begin
            if (req_ready_o) ready_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!resp_valid_o) check("resp_timeout", 32'd0, 32'd1);
        instr = instr_o;
        $display("fetch addr=%h instr=%h latency=%0d hits=%0d misses=%0d",
                 a, instr, lat, hit_cnt_o, miss_cnt_o);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int          lat;
        bit          rb;
        int          base;
        int          w;

        // 1: reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_memreq", {31'd0, mem_req_o}, 32'd0);
        check("rst_resp", {31'd0, resp_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_memaddr", mem_addr_o, 32'd0);
        check("rst_hits", hit_cnt_o, 32'd0);
        check("rst_misses", miss_cnt_o, 32'd0);
        rst_n = 1'b1;

        // 2: cold miss then hit in the same line
        data_tag = 8'hA0;
        fetch(32'h104, ins, lat, rb);
        check("t2_instr", ins, 32'hA000_0104);
        check("t2_line", last_line, 32'h100);
        check("t2_ready_busy", {31'd0, rb}, 32'd0);
        check("t2_misses", miss_cnt_o, 32'd1);
        base = n_mem_req;
        fetch(32'h108, ins, lat, rb);
        check("t2_hit_instr", ins, 32'hA000_0108);
        check("t2_hit_lat", lat, 32'd2);
        check("t2_hits", hit_cnt_o, 32'd1);
        check("t2_no_memreq", n_mem_req - base, 32'd0);
        @(negedge clk);
        check("t2_resp_pulse", {31'd0, resp_valid_o}, 32'd0);

        // 3: round-robin replacement within set 0
        do_reset();
        data_tag = 8'hB0;
        base = n_mem_req;
        for (int i = 0; i < 5; i++) fetch(32'(i * 32'h100), ins, lat, rb);
        check("t3_five_misses", n_mem_req - base, 32'd5);
        check("t3_instr_400", ins, 32'hB000_0400);
        fetch(32'h000, ins, lat, rb);
        check("t3_evicted", n_mem_req - base, 32'd6);
        check("t3_instr_000", ins, 32'hB000_0000);
        fetch(32'h200, ins, lat, rb);
        check("t3_hit_200", ins, 32'hB000_0200);
        check("t3_hit_lat", lat, 32'd2);
        check("t3_misses", miss_cnt_o, 32'd6);
        check("t3_hits", hit_cnt_o, 32'd1);

        // 4: delayed grant and gaps between beats
        data_tag = 8'hC0;
        gnt_delay = 3;
        beat_gap = 2;
        fetch(32'h3C8, ins, lat, rb);
        check("t4_instr", ins, 32'hC000_03C8);
        check("t4_line", last_line, 32'h3C0);
        check("t4_ready_busy", {31'd0, rb}, 32'd0);
        check("t4_misses", miss_cnt_o, 32'd7);

        // 5: flush raised during a burst
        data_tag = 8'hD0;
        gnt_delay = 0;
        beat_gap = 1;
        flush_in_burst = 1'b1;
        fetch(32'h040, ins, lat, rb);
        flush_in_burst = 1'b0;
        check("t5_instr", ins, 32'hD000_0040);
        @(negedge clk);
        check("t5_ready_flushing", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        check("t5_ready_after", {31'd0, req_ready_o}, 32'd1);
        data_tag = 8'hE0;
        base = n_mem_req;
        fetch(32'h040, ins, lat, rb);
        check("t5_refetch_miss", n_mem_req - base, 32'd1);
        check("t5_refetch_instr", ins, 32'hE000_0040);
        fetch(32'h3CC, ins, lat, rb);
        check("t5_old_line_gone", n_mem_req - base, 32'd2);
        check("t5_instr_3cc", ins, 32'hE000_03CC);
        check("t5_misses", miss_cnt_o, 32'd10);

        // 6: asynchronous reset in the middle of a burst
        data_tag = 8'hF0;
        beat_gap = 2;
        @(negedge clk);
        req_valid_i = 1'b1;
        addr_i = 32'h104;
        @(negedge clk);
        req_valid_i = 1'b0;
        w = 0;
        while (!mem_gnt_i && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("t6_grant_seen", {31'd0, mem_gnt_i}, 32'd1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("t6_rst_memreq", {31'd0, mem_req_o}, 32'd0);
        check("t6_rst_resp", {31'd0, resp_valid_o}, 32'd0);
        check("t6_rst_misses", miss_cnt_o, 32'd0);
        check("t6_rst_hits", hit_cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        data_tag = 8'h55;
        base = n_mem_req;
        fetch(32'h104, ins, lat, rb);
        check("t6_fresh_miss", n_mem_req - base, 32'd1);
        check("t6_instr", ins, 32'h5500_0104);
        check("t6_misses", miss_cnt_o, 32'd1);
        fetch(32'h10C, ins, lat, rb);
        check("t6_hit_instr", ins, 32'h5500_010C);
        check("t6_hits", hit_cnt_o, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
